// File: rtl/ipif_regfile_pkg.sv
// Shared helpers for the IPIF register file: clog2, access-FSM state encoding
// and index-range helpers that locate the WO / RW / RO windows.
package ipif_regfile_pkg;

  localparam int MAX_REGS_PER_BANK = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } ack_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int rw_base(input int num_wo);
    return num_wo;
  endfunction

  function automatic int ro_base(input int num_wo, input int num_rw);
    return num_wo + num_rw;
  endfunction

  function automatic int total_regs(input int num_wo, input int num_rw, input int num_ro);
    return num_wo + num_rw + num_ro;
  endfunction

endpackage

// File: rtl/ipif_ack_fsm.sv
// IDLE/ACK/HOLD access sequencer: one commit and one registered ack pulse per
// chip-select assertion; CS must drop before the next access is accepted.
module ipif_ack_fsm
  import ipif_regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cs_i,
  input  logic rnw_i,
  output logic commit_o,
  output logic wr_ack_o,
  output logic rd_ack_o
);

  ack_state_e state_q;
  logic       wr_ack_q;
  logic       rd_ack_q;

  assign commit_o = (state_q == ST_IDLE) && cs_i;
  assign wr_ack_o = wr_ack_q;
  assign rd_ack_o = rd_ack_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (cs_i) begin
          state_q  <= ST_ACK;
          wr_ack_q <= !rnw_i;
          rd_ack_q <= rnw_i;
        end
        ST_ACK:  state_q <= ST_HOLD;
        ST_HOLD: if (!cs_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ipif_regfile.sv
// IPIF slave register file with write-only, read-write and read-only banks.
// Define IPIF_REGFILE_ERR_EN to flag RO writes and out-of-range accesses on IP2Bus_Error.
module ipif_regfile
  import ipif_regfile_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_WO_REGS        = 4,
  parameter int NUM_RW_REGS        = 4,
  parameter int NUM_RO_REGS        = 4,
  parameter logic [NUM_WO_REGS*C_S_AXI_DATA_WIDTH-1:0] WO_DEFAULTS = '0,
  parameter logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] RW_DEFAULTS = '0
) (
  input  logic                                        Bus2IP_Clk,
  input  logic                                        Bus2IP_Resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               Bus2IP_Addr,
  input  logic                                        Bus2IP_CS,
  input  logic                                        Bus2IP_RNW,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]               Bus2IP_Data,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]             Bus2IP_BE,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               IP2Bus_Data,
  output logic                                        IP2Bus_RdAck,
  output logic                                        IP2Bus_WrAck,
  output logic                                        IP2Bus_Error,
  output logic [NUM_WO_REGS*C_S_AXI_DATA_WIDTH-1:0]   wo_regs,
  output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0]   rw_regs,
  input  logic [NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0]   ro_regs,
  output logic [NUM_WO_REGS+NUM_RW_REGS-1:0]          wr_strb,
  output logic [NUM_RO_REGS-1:0]                      rd_strb
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int BW    = DW / 8;
  localparam int LSB   = clog2(BW);
  localparam int TOTAL = total_regs(NUM_WO_REGS, NUM_RW_REGS, NUM_RO_REGS);
  localparam int IW    = clog2(TOTAL);
  localparam int RW_LO = rw_base(NUM_WO_REGS);
  localparam int RO_LO = ro_base(NUM_WO_REGS, NUM_RW_REGS);

  logic [IW-1:0] idx;
  int            idx_n;
  logic          commit;
  logic          wr_commit;
  logic          rd_commit;
  logic          unused_addr;

  logic [NUM_WO_REGS*DW-1:0]          wo_q;
  logic [NUM_RW_REGS*DW-1:0]          rw_q;
  logic [DW-1:0]                      rd_data_d;
  logic [DW-1:0]                      rd_data_q;
  logic [NUM_WO_REGS+NUM_RW_REGS-1:0] wr_strb_q;
  logic [NUM_RO_REGS-1:0]             rd_strb_q;

  // Upper address bits alias onto the register window by design.
  assign unused_addr = ^Bus2IP_Addr;
  assign idx         = Bus2IP_Addr[LSB +: IW];
  assign idx_n       = int'(idx);
  assign wr_commit   = commit && !Bus2IP_RNW;
  assign rd_commit   = commit && Bus2IP_RNW;

  ipif_ack_fsm u_fsm (
    .clk      (Bus2IP_Clk),
    .rst_n    (Bus2IP_Resetn),
    .cs_i     (Bus2IP_CS),
    .rnw_i    (Bus2IP_RNW),
    .commit_o (commit),
    .wr_ack_o (IP2Bus_WrAck),
    .rd_ack_o (IP2Bus_RdAck)
  );

  // NOTE: every variable gets a default before the selects so no latch is inferred.
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_RW_REGS; k++)
      if (idx_n == RW_LO + k) rd_data_d = rw_q[k*DW +: DW];
    for (int k = 0; k < NUM_RO_REGS; k++)
      if (idx_n == RO_LO + k) rd_data_d = ro_regs[k*DW +: DW];
  end

  // NOTE: the register banks are software-visible state, so they reset to their
  // parameterised defaults rather than being left uninitialised like a RAM.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      wo_q      <= WO_DEFAULTS;
      rw_q      <= RW_DEFAULTS;
      rd_data_q <= '0;
      wr_strb_q <= '0;
      rd_strb_q <= '0;
    end else begin
      wr_strb_q <= '0;
      rd_strb_q <= '0;
      for (int k = 0; k < NUM_WO_REGS; k++) begin
        if (wr_commit && idx_n == k) begin
          wr_strb_q[k] <= 1'b1;
          for (int b = 0; b < BW; b++)
            if (Bus2IP_BE[b]) wo_q[k*DW + b*8 +: 8] <= Bus2IP_Data[b*8 +: 8];
        end
      end
      for (int k = 0; k < NUM_RW_REGS; k++) begin
        if (wr_commit && idx_n == RW_LO + k) begin
          wr_strb_q[RW_LO + k] <= 1'b1;
          for (int b = 0; b < BW; b++)
            if (Bus2IP_BE[b]) rw_q[k*DW + b*8 +: 8] <= Bus2IP_Data[b*8 +: 8];
        end
      end
      for (int k = 0; k < NUM_RO_REGS; k++)
        if (rd_commit && idx_n == RO_LO + k) rd_strb_q[k] <= 1'b1;
      if (rd_commit) rd_data_q <= rd_data_d;
    end
  end

`ifdef IPIF_REGFILE_ERR_EN
  logic err_q;

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) err_q <= 1'b0;
    else err_q <= (wr_commit && idx_n >= RO_LO) || (rd_commit && idx_n >= TOTAL);
  end

  assign IP2Bus_Error = err_q;
`else
  assign IP2Bus_Error = 1'b0;
`endif

  assign IP2Bus_Data = rd_data_q;
  assign wo_regs     = wo_q;
  assign rw_regs     = rw_q;
  assign wr_strb     = wr_strb_q;
  assign rd_strb     = rd_strb_q;

endmodule
